// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I data memory with byte-lane stores, sign/zero-extended loads and sticky fault logging
module dmem_lsu #(
  parameter int DEPTH_WORDS = 256,
  localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misaligned,
  input  logic        clr_err,
  output logic        err_sticky,
  output logic [1:0]  err_cause,
  output logic [31:0] err_addr
);
  logic [31:0] r_mem [DEPTH_WORDS];
  logic r_sticky;
  logic [1:0] r_cause;
  logic [31:0] r_addr;
  logic w_active, w_legal, w_misal, w_fault;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0] w_word, w_wdata;
  logic [3:0] w_be;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  // a combined load+store is judged against the stricter store legality set
  always_comb begin
    w_active = mem_read | mem_write;
    w_legal = mem_write ? (funct3 inside {3'b000, 3'b001, 3'b010})
                        : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    w_misal = w_active & w_legal & ((funct3[1:0] == 2'b01 & addr[0]) | (funct3[1:0] == 2'b10 & |addr[1:0]));
    w_fault = w_misal | (w_active & ~w_legal);
    w_idx = addr[ADDR_W+1:2];
    w_word = r_mem[w_idx];
    w_byte = w_word[{addr[1:0], 3'b000} +: 8];
    w_half = addr[1] ? w_word[31:16] : w_word[15:0];
    w_be = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] : funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_wdata = funct3[1:0] == 2'b00 ? {4{write_data[7:0]}} : funct3[1:0] == 2'b01 ? {2{write_data[15:0]}} : write_data;
    read_data = (~mem_read | w_fault) ? 32'd0
              : funct3[1:0] == 2'b00 ? {{24{~funct3[2] & w_byte[7]}}, w_byte}
              : funct3[1:0] == 2'b01 ? {{16{~funct3[2] & w_half[15]}}, w_half}
              : w_word;
  end
  always_ff @(posedge clk)
    if (mem_write & ~w_fault)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      r_sticky <= 1'b0;
      r_cause <= 2'b00;
      r_addr <= 32'd0;
    end else if (w_fault & (~r_sticky | clr_err)) begin
      r_sticky <= 1'b1;
      r_cause <= w_misal ? 2'b01 : 2'b10;
      r_addr <= addr;
    end else if (clr_err) begin
      r_sticky <= 1'b0;
      r_cause <= 2'b00;
      r_addr <= 32'd0;
    end
  assign misaligned = w_misal;
  assign err_sticky = r_sticky;
  assign err_cause = r_cause;
  assign err_addr = r_addr;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed vector table plus randomized traffic against a byte-array reference model
module tb_dmem_lsu;
  logic clk = 0, rst = 0, mem_read = 0, mem_write = 0, clr_err = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, write_data = 0, read_data, err_addr;
  logic misaligned, err_sticky;
  logic [1:0] err_cause;
  int checks = 0, failures = 0;

  dmem_lsu dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .write_data(write_data), .read_data(read_data), .misaligned(misaligned),
    .clr_err(clr_err), .err_sticky(err_sticky), .err_cause(err_cause), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  logic [7:0] mm [1024];
  logic m_st;
  logic [1:0] m_ca;
  logic [31:0] m_ea;

  typedef struct {
    logic r, w;
    logic [2:0] f;
    logic [31:0] a, d;
    logic c, x;
    logic [31:0] e_rd;
    logic e_mis, e_st;
    logic [1:0] e_ca;
    logic [31:0] e_ea;
  } vec_t;
  vec_t tv [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic legal(input logic w, input logic [2:0] f);
    return w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
  endfunction

  // one cycle: comb outputs checked against the model before the edge, error registers after it
  task automatic step(input logic r, w, input logic [2:0] f, input logic [31:0] a, d,
                      input logic c, x, input logic has_exp, input logic [31:0] e_rd,
                      input logic e_mis, e_st, input logic [1:0] e_ca, input logic [31:0] e_ea);
    int size;
    logic act, lg, mis, flt;
    logic [31:0] v;
    @(negedge clk);
    mem_read = r; mem_write = w; funct3 = f; addr = a; write_data = d; clr_err = c; rst = x;
    act = r | w;
    lg = legal(w, f);
    size = 1 << f[1:0];
    mis = act && lg && (int'(a[1:0]) % size != 0);
    flt = mis || (act && !lg);
    v = 0;
    if (r && !flt) begin
      for (int i = 0; i < size; i++) v |= 32'(mm[(a + i) & 1023]) << (8 * i);
      if (!f[2] && size < 4 && v[8*size-1]) v |= ~((32'd1 << (8 * size)) - 1);
    end
    #1;
    chk("read_data", read_data, v);
    chk("misaligned", 32'(misaligned), 32'(mis));
    if (has_exp) begin
      chk("vec_read_data", read_data, e_rd);
      chk("vec_misaligned", 32'(misaligned), 32'(e_mis));
    end
    @(posedge clk);
    if (w && !flt) for (int i = 0; i < size; i++) mm[(a + i) & 1023] = d[8*i +: 8];
    if (x) begin m_st = 0; m_ca = 0; m_ea = 0; end
    else if (flt && (!m_st || c)) begin m_st = 1; m_ca = mis ? 2'b01 : 2'b10; m_ea = a; end
    else if (c) begin m_st = 0; m_ca = 0; m_ea = 0; end
    #1;
    chk("err_sticky", 32'(err_sticky), 32'(m_st));
    chk("err_cause", 32'(err_cause), 32'(m_ca));
    chk("err_addr", err_addr, m_ea);
    if (has_exp) begin
      chk("vec_err_sticky", 32'(err_sticky), 32'(e_st));
      chk("vec_err_cause", 32'(err_cause), 32'(e_ca));
      chk("vec_err_addr", err_addr, e_ea);
    end
  endtask

  initial begin
    tv[0]  = '{0,1,2,32'h10,32'hDEADBEEF,0,0, 32'h0,0,0,0,0};
    tv[1]  = '{1,0,2,32'h10,0,0,0, 32'hDEADBEEF,0,0,0,0};
    tv[2]  = '{1,0,0,32'h11,0,0,0, 32'hFFFFFFBE,0,0,0,0};
    tv[3]  = '{1,0,4,32'h13,0,0,0, 32'h000000DE,0,0,0,0};
    tv[4]  = '{1,0,5,32'h12,0,0,0, 32'h0000DEAD,0,0,0,0};
    tv[5]  = '{1,0,1,32'h10,0,0,0, 32'hFFFFBEEF,0,0,0,0};
    tv[6]  = '{0,1,2,32'h20,32'h0,0,0, 32'h0,0,0,0,0};
    tv[7]  = '{0,1,0,32'h22,32'h001234AB,0,0, 32'h0,0,0,0,0};
    tv[8]  = '{0,1,1,32'h20,32'h0000CD77,0,0, 32'h0,0,0,0,0};
    tv[9]  = '{1,0,2,32'h20,0,0,0, 32'h00ABCD77,0,0,0,0};
    tv[10] = '{0,1,2,32'h30,32'h11111111,0,0, 32'h0,0,0,0,0};
    tv[11] = '{0,1,2,32'h31,32'h22222222,0,0, 32'h0,1,1,1,32'h31};
    tv[12] = '{1,0,2,32'h30,0,0,0, 32'h11111111,0,1,1,32'h31};
    tv[13] = '{1,0,1,32'h33,0,0,0, 32'h0,1,1,1,32'h31};
    tv[14] = '{1,0,3,32'h40,0,1,0, 32'h0,0,1,2,32'h40};
    tv[15] = '{0,0,0,32'h0,0,1,0, 32'h0,0,0,0,0};
    tv[16] = '{0,1,2,32'h400,32'hA5A5A5A5,0,0, 32'h0,0,0,0,0};
    tv[17] = '{1,0,2,32'h0,0,0,0, 32'hA5A5A5A5,0,0,0,0};
    tv[18] = '{1,1,2,32'h0,32'h5,0,0, 32'hA5A5A5A5,0,0,0,0};
    tv[19] = '{1,0,2,32'h0,0,0,0, 32'h5,0,0,0,0};
    tv[20] = '{1,0,2,32'h2,0,0,0, 32'h0,1,1,1,32'h2};
    tv[21] = '{0,1,2,32'h8,32'h77,0,1, 32'h0,0,0,0,0};
    tv[22] = '{1,0,2,32'h8,0,0,0, 32'h77,0,0,0,0};
    tv[23] = '{0,0,2,32'h8,0,0,0, 32'h0,0,0,0,0};
    tv[24] = '{0,1,4,32'h50,32'h99,0,0, 32'h0,0,1,2,32'h50};
    tv[25] = '{0,0,0,32'h0,0,1,0, 32'h0,0,0,0,0};
    m_st = 0; m_ca = 0; m_ea = 0;
    step(0,0,0,0,0,0,1, 1, 0,0,0,0,0);
    step(0,0,0,0,0,0,1, 1, 0,0,0,0,0);
    for (int i = 0; i < 256; i++) step(0,1,2,32'(i*4),$urandom,0,0, 0, 0,0,0,0,0);
    foreach (tv[i])
      step(tv[i].r, tv[i].w, tv[i].f, tv[i].a, tv[i].d, tv[i].c, tv[i].x,
           1, tv[i].e_rd, tv[i].e_mis, tv[i].e_st, tv[i].e_ca, tv[i].e_ea);
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      step(op < 7 || op == 15, op >= 7, 3'($urandom), 32'($urandom_range(0, 2047)), $urandom,
           $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, 0, 0,0,0,0,0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Data memory with an integrated load/store formatting unit for the single-cycle RV32I core.
- Sits directly upstream of the writeback mux: read_data feeds the mux data-memory input, and mem2reg selects it over the ALU result.
- Performs byte, half and word stores through byte enables, and sign- or zero-extends loads.
- Detects misaligned and illegal-size accesses and logs the first fault in sticky status registers.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two.
- ADDR_W, $clog2(DEPTH_WORDS), word-index width, derived; do not override.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  load enable (control unit MemRead).
- mem_write  input  1  store enable (control unit MemWrite).
- funct3  input  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- addr  input  32  byte address from the ALU.
- write_data  input  32  rs2 value; data occupies the low bits.
- read_data  output  32  formatted load result to the writeback mux.
- misaligned  output  1  combinational; current access is misaligned.
- clr_err  input  1  clears the sticky error state.
- err_sticky  output  1  a fault has occurred since reset or the last clear.
- err_cause  output  2  01 misaligned, 10 illegal funct3, 00 none.
- err_addr  output  32  addr of the first logged fault.

Behaviour:
- Storage: DEPTH_WORDS x 32 array, little-endian. Word index is addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS. rst does not alter array contents.
- Access active when mem_read|mem_write.
- Alignment rules:
  - Half access needs addr[0]=0.
  - Word access needs addr[1:0]=00.
  - Byte access is always aligned.
- misaligned = active & legal funct3 & alignment violated. It is combinational, so it is valid in the same cycle.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any funct3 other than 000, 001, 010. Store with 100/101 is illegal.
- Faulting access (misaligned or illegal): the write is suppressed and read_data = 0.
- Store (mem_write=1, no fault): on the clk edge, only the addressed lanes are written.
  - sb writes byte addr[1:0] with write_data[7:0].
  - sh writes bytes {addr[1],0} and {addr[1],1} with write_data[15:0].
  - sw writes all 4 bytes.
  - Non-addressed bytes are unchanged.
- Load (mem_read=1, no fault): read_data is combinational (zero-latency) from the current array contents.
  - lb/lbu select byte addr[1:0]; lh/lhu select half addr[1].
  - Signed forms sign-extend bit 7 or bit 15 to 32 bits; unsigned forms zero-extend.
  - lw returns the whole word.
- mem_read=0 -> read_data = 0.
- mem_read & mem_write in the same cycle:
  - The store is performed at the edge.
  - read_data in that cycle shows pre-edge contents (read-before-write).
  - Fault checks apply to both and are evaluated once on funct3/addr. Legality follows the stricter store set.
- Error registers:
  - rst -> err_sticky=0, err_cause=00, err_addr=0.
  - Fault with err_sticky=0 -> at the edge, err_sticky=1, err_cause and err_addr are captured.
  - Fault with err_sticky=1 -> no update; the first fault is retained.
  - clr_err alone -> all three registers cleared.
  - clr_err together with a fault in the same cycle -> the new fault is captured (fault wins).
  - rst has priority over everything.
- Reset mid-operation: a store presented in the rst cycle is still written to the array, because the array is not reset. Only the error registers clear.
- Width: all extension is explicit to 32 bits. There is no carry or overflow logic.

Test Plan:
1. sw 0xDEADBEEF @0x10, then lw @0x10 -> 0xDEADBEEF; lb @0x11 -> 0xFFFFFFBE; lbu @0x13 -> 0x000000DE; lhu @0x12 -> 0x0000DEAD; lh @0x10 -> 0xFFFFBEEF.
2. sw 0 @0x20, sb 0x1234AB @0x22, sh 0xCD77 @0x20, then lw @0x20 -> 0x00ABCD77 (untouched lanes preserved).
3. sw 0x11111111 @0x30, then sw 0x22222222 @0x31 -> misaligned=1 that cycle, write suppressed, lw @0x30 = 0x11111111, err_sticky=1, err_cause=01, err_addr=0x31. A following lh @0x33 leaves err_addr at 0x31.
4. With err_sticky set, lw funct3=011 @0x40 with clr_err=1 -> err_cause=10, err_addr=0x40, read_data=0. The next cycle clr_err alone -> all error regs 0.
5. Wrap: DEPTH_WORDS=256; sw 0xA5A5A5A5 @0x400 -> lw @0x000 returns 0xA5A5A5A5. Simultaneous mem_read+mem_write sw 0x5 @0x0 -> read_data shows 0xA5A5A5A5 that cycle, 0x5 after.
6. rst asserted with a pending fault and a sw 0x77 @0x8 -> error regs 0 after the edge, lw @0x8 = 0x77; mem_read=0 -> read_data=0.
